// File: rtl/pipeline_stall_controller.sv
// Hazard consumer for the 5-stage RV32I pipeline.
// Compares the ID-stage sources against the EX and MEM destinations.
// From those matches and the memory-busy and branch inputs it drives the
// PC/IF/ID enables, the IF/ID flush, the ID/EX bubble and the EX forwarding
// selects. It also keeps a data-memory freeze watchdog and two saturating
// stall counters.
//
// Handshake: there is no valid/ready pair here. Every control output is a
// level that the pipeline registers sample on the same rising clk edge.
// pc_write_en / if_id_write_en = 1 means "load this edge".
// if_id_flush / id_ex_bubble = 1 means "load a NOP this edge".
module pipeline_stall_controller #(
    parameter int CNT_W        = 16,
    parameter int FREEZE_LIMIT = 255
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic             dmem_busy,
    input  logic             imem_busy,
    input  logic             branch_taken_ex,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [1:0]       fwd_sel_rs1,
    output logic [1:0]       fwd_sel_rs2,
    output logic [1:0]       state,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] load_stalls
);

    localparam logic [1:0] ST_RUN     = 2'b00;
    localparam logic [1:0] ST_FREEZE  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // The freeze counter only has to reach FREEZE_LIMIT. One extra bit is
    // kept on the incremented value so the limit compare cannot wrap.
    localparam int               FC_W      = (FREEZE_LIMIT < 2) ? 1 : $clog2(FREEZE_LIMIT + 1);
    localparam logic [FC_W:0]    LIMIT_EXT = (FC_W + 1)'(FREEZE_LIMIT);

    logic            rs1_ex, rs2_ex, rs1_mem, rs2_mem;
    logic            load_use;
    logic            sel_freeze, sel_load_use;
    logic [FC_W-1:0] freeze_cnt;
    logic [FC_W:0]   freeze_inc;
    logic [1:0]      next_fwd_rs1, next_fwd_rs2;

    // Dependency matches. x0 is hard-wired to zero, so it never forwards or stalls.
    always_comb begin
        rs1_ex   = id_uses_rs1 & ex_reg_write  & (ex_rd  != 5'd0) & (ex_rd  == id_rs1);
        rs2_ex   = id_uses_rs2 & ex_reg_write  & (ex_rd  != 5'd0) & (ex_rd  == id_rs2);
        rs1_mem  = id_uses_rs1 & mem_reg_write & (mem_rd != 5'd0) & (mem_rd == id_rs1);
        rs2_mem  = id_uses_rs2 & mem_reg_write & (mem_rd != 5'd0) & (mem_rd == id_rs2);
        load_use = ex_mem_read & (rs1_ex | rs2_ex);
    end

    // Prioritised pipeline controls: freeze > branch > load-use > imem wait > run.
    always_comb begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;
        sel_freeze     = 1'b0;
        sel_load_use   = 1'b0;
        if (RESET) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            if_id_flush    = 1'b1;
            id_ex_bubble   = 1'b1;
        end else if (dmem_busy) begin
            // Whole pipe holds; a pending branch stays in EX until memory frees up.
            sel_freeze     = 1'b1;
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
        end else if (branch_taken_ex) begin
            // The younger dependent instruction is squashed, so no load-use stall.
            if_id_write_en = 1'b0;
            if_id_flush    = 1'b1;
            id_ex_bubble   = 1'b1;
        end else if (load_use) begin
            sel_load_use   = 1'b1;
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_bubble   = 1'b1;
        end else if (imem_busy) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            if_id_flush    = 1'b1;
        end
    end

    // Forwarding select for the instruction about to enter EX. EX/MEM beats MEM/WB.
    always_comb begin
        next_fwd_rs1 = fwd_sel_rs1;
        next_fwd_rs2 = fwd_sel_rs2;
        if (!sel_freeze) begin
            if (id_ex_bubble) begin
                next_fwd_rs1 = FWD_RF;
                next_fwd_rs2 = FWD_RF;
            end else begin
                next_fwd_rs1 = rs1_ex ? FWD_EX : (rs1_mem ? FWD_MEM : FWD_RF);
                next_fwd_rs2 = rs2_ex ? FWD_EX : (rs2_mem ? FWD_MEM : FWD_RF);
            end
        end
    end

    // Register the forwarding selects so they line up with the ID/EX register.
    always_ff @(posedge clk) begin
        if (RESET) begin
            fwd_sel_rs1 <= FWD_RF;
            fwd_sel_rs2 <= FWD_RF;
        end else begin
            fwd_sel_rs1 <= next_fwd_rs1;
            fwd_sel_rs2 <= next_fwd_rs2;
        end
    end

    assign freeze_inc = {1'b0, freeze_cnt} + 1'b1;

    // Freeze watchdog FSM. It counts consecutive dmem_busy cycles, including the
    // cycle that leaves RUN, and raises a sticky timeout at FREEZE_LIMIT.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state       <= ST_RUN;
            freeze_cnt  <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (dmem_busy) begin
                        freeze_cnt <= FC_W'(1);
                        if (LIMIT_EXT <= (FC_W + 1)'(1)) begin
                            state       <= ST_TIMEOUT;
                            mem_timeout <= 1'b1;
                        end else begin
                            state <= ST_FREEZE;
                        end
                    end
                end
                ST_FREEZE: begin
                    if (dmem_busy) begin
                        freeze_cnt <= freeze_inc[FC_W-1:0];
                        if (freeze_inc >= LIMIT_EXT) begin
                            state       <= ST_TIMEOUT;
                            mem_timeout <= 1'b1;
                        end
                    end else begin
                        state      <= ST_RUN;
                        freeze_cnt <= '0;
                    end
                end
                ST_TIMEOUT: begin
                    if (!dmem_busy) begin
                        state      <= ST_RUN;
                        freeze_cnt <= '0;
                    end
                end
                default: begin
                    state      <= ST_RUN;
                    freeze_cnt <= '0;
                end
            endcase
        end
    end

    // Saturating performance counters: PC-hold cycles and load-use bubbles.
    always_ff @(posedge clk) begin
        if (RESET) begin
            stall_cycles <= '0;
            load_stalls  <= '0;
        end else begin
            if (!pc_write_en && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + 1'b1;
            if (sel_load_use && (load_stalls != {CNT_W{1'b1}}))
                load_stalls <= load_stalls + 1'b1;
        end
    end

endmodule
